prog_mem_ctrl: RTL and testbench
================================

// Module: prog_mem_ctrl
// PURPOSE
//  Parametrised program memory for the microcontroller core, with a streaming loader and a registered fetch port.
//  The loader writes a block of words from a base address using a valid/ready handshake, auto-increments the
//  address and keeps a running checksum. The fetch port serves the instruction decoder and is blocked while a load runs.
// PARAMETERS
//  INSTR_W   14  instruction word width, bits
//  ADDR_W    8   address width; DEPTH = 2**ADDR_W words (localparam)
// PORTS
//  clk             in   1         single clock, all logic on rising edge
//  i_reset         in   1         synchronous, active-high reset
//  i_enable        in   1         fetch request this cycle
//  i_address       in   ADDR_W    fetch address
//  o_instruction   out  INSTR_W   fetched word, registered
//  o_instr_valid   out  1         o_instruction holds a valid word this cycle
//  i_load_start    in   1         start load session (sampled only in IDLE)
//  i_load_base     in   ADDR_W    first write address, captured on start
//  i_load_count    in   ADDR_W+1  word count, 0..DEPTH, captured on start
//  i_load_valid    in   1         i_load_data valid
//  i_load_data     in   INSTR_W   word to write
//  o_load_ready    out  1         loader accepts a word this cycle
//  o_load_done     out  1         one-cycle pulse when a session ends
//  o_busy          out  1         load session active
//  o_checksum      out  INSTR_W   sum mod 2**INSTR_W of words written in the last/current session
//  o_parity_err    out  1         fetched word parity mismatch (constant 0 without macro)
// BEHAVIOUR
//  - Reset: state IDLE; o_instruction=0, o_instr_valid=0, o_load_ready=0, o_load_done=0, o_busy=0, o_checksum=0,
//    o_parity_err=0. Array contents are NOT reset. Reset mid-load aborts the session: no o_load_done, words already written stay.
//  - FSM IDLE -> LOAD on i_load_start (captures base, count, clears checksum); count==0 -> DONE directly.
//    LOAD: o_load_ready=1, o_busy=1; each cycle with valid&&ready writes data at the current address, address+1
//    (wraps DEPTH-1 -> 0), remaining-1, checksum+=data. The last word moves to DONE. DONE: o_load_done=1 for one cycle, then IDLE.
//  - i_load_start in LOAD/DONE is ignored. i_load_valid with ready low is ignored and never written.
//  - Fetch: in IDLE, i_enable at cycle N -> o_instruction=mem[i_address], o_instr_valid=1 at N+1 (1-cycle latency).
//    With i_enable low, or in LOAD/DONE: o_instr_valid=0 and o_instruction=0 at N+1.
//  - Read-during-write cannot occur: fetch is blocked while loading. A fetch in the cycle after DONE sees the new data.
//  - o_checksum holds its value after DONE until the next start.
// CONFIGURATION
//  PROG_MEM_PARITY_EN defined: array width INSTR_W+1, even-parity bit stored on each write; o_parity_err=1 with
//    o_instr_valid when the fetched word+parity has odd weight; otherwise 0.
//  Undefined: array width INSTR_W, o_parity_err tied 0.
// STRUCTURE
//  prog_mem_pkg: state enum {IDLE, LOAD, DONE}, default widths INSTR_W_DEF=14, ADDR_W_DEF=8.
//  Sub-module prog_mem_array: 1 write / 1 synchronous read port, parametrised width/depth, no reset. The controller
//  holds the FSM, counters, checksum and fetch gating.
// TESTING
//  1. Reset, then fetch addr 0x05 -> o_instr_valid=1 one cycle later; o_parity_err=0 after array preloaded via loader.
//  2. Start base=0x10 count=3, data 0x0001,0x0002,0x3FFF -> mem[0x10..0x12] written, o_checksum=0x0002, done pulse once.
//  3. Base=0xFE count=4 -> writes 0xFE,0xFF,0x00,0x01 (wrap); fetch during load -> o_instr_valid=0.
//  4. Valid toggling 1,0,1,1 with count=3 -> exactly 3 writes; start pulse mid-load ignored; count=0 -> done next+1 cycle.
//  5. i_reset after 2 of 5 words -> IDLE, no done, the 2 words persist, o_checksum=0.
//  6. With PROG_MEM_PARITY_EN, force a flipped bit in the array -> o_parity_err=1 on that fetch.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// ---------------------------------------------------------------------------
// prog_mem_pkg
// Shared definitions for the program memory block.
//   INSTR_W_DEF : default instruction word width (bits)
//   ADDR_W_DEF  : default address width (depth = 2**ADDR_W words)
//   state_t     : loader FSM states IDLE / LOAD / DONE
// ---------------------------------------------------------------------------
package prog_mem_pkg;

    localparam int INSTR_W_DEF = 14;
    localparam int ADDR_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/prog_mem_array.sv
// ---------------------------------------------------------------------------
// prog_mem_array
// Storage array with one write port and one synchronous read port.
// The contents are deliberately not reset.
// Ports:
//   clk       : clock, all activity on the rising edge
//   wrEn_i    : write enable
//   wrAddr_i  : write address
//   wrData_i  : write data
//   rdEn_i    : read enable; when low the read register holds its value
//   rdAddr_i  : read address
//   rdData_o  : registered read data (one-cycle latency)
// ---------------------------------------------------------------------------
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int WIDTH  = INSTR_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [WIDTH-1:0]  wrData_i,
    input  logic              rdEn_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [WIDTH-1:0]  rdData_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdData_q;

    // Write port and registered read port share the clock. The controller
    // never reads and writes in the same cycle, so read-during-write
    // ordering does not matter here.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
        if (rdEn_i) begin
            rdData_q <= mem[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/prog_mem_ctrl.sv
// ---------------------------------------------------------------------------
// prog_mem_ctrl
// Program memory for the microcontroller core: a streaming loader that writes
// a block of words from a base address (valid/ready handshake, address
// auto-increment with wrap, running checksum) and a registered fetch port
// for the instruction decoder, blocked while a load session is active.
//
// Optional feature macro: PROG_MEM_PARITY_EN
//   defined   : an even-parity bit is stored with every word and checked on
//               every fetch, reported on o_parity_err
//   undefined : no parity storage, o_parity_err tied low
//
// Ports:
//   clk            : clock
//   i_reset        : synchronous active-high reset
//   i_enable       : fetch request
//   i_address      : fetch address
//   o_instruction  : fetched word (zero when o_instr_valid is low)
//   o_instr_valid  : o_instruction holds a fetched word
//   i_load_start   : start a load session (only honoured in IDLE)
//   i_load_base    : first write address of the session
//   i_load_count   : number of words in the session, 0..DEPTH
//   i_load_valid   : i_load_data is valid
//   i_load_data    : word to write
//   o_load_ready   : loader accepts a word this cycle
//   o_load_done    : one-cycle pulse at the end of a session
//   o_busy         : load session active
//   o_checksum     : sum (mod 2**INSTR_W) of words written this/last session
//   o_parity_err   : fetched word failed its parity check
// ---------------------------------------------------------------------------
module prog_mem_ctrl
    import prog_mem_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [INSTR_W-1:0] o_instruction,
    output logic               o_instr_valid,
    input  logic               i_load_start,
    input  logic [ADDR_W-1:0]  i_load_base,
    input  logic [ADDR_W:0]    i_load_count,
    input  logic               i_load_valid,
    input  logic [INSTR_W-1:0] i_load_data,
    output logic               o_load_ready,
    output logic               o_load_done,
    output logic               o_busy,
    output logic [INSTR_W-1:0] o_checksum,
    output logic               o_parity_err
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef PROG_MEM_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
`else
    localparam int MEM_W = INSTR_W;
`endif

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    state_t               state_q,     state_d;
    logic [ADDR_W-1:0]    loadAddr_q,  loadAddr_d;
    logic [ADDR_W:0]      remaining_q, remaining_d;
    logic [INSTR_W-1:0]   checksum_q,  checksum_d;
    logic                 instrValid_q, instrValid_d;

    logic                 memWrEn;
    logic [MEM_W-1:0]     memWrData;
    logic                 fetchEn;
    logic [MEM_W-1:0]     memRdData;

    // State, loader counters, checksum and fetch-valid flag. Reset drops any
    // session in progress without a done pulse; words already written stay
    // in the array because the array itself has no reset.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            loadAddr_q   <= '0;
            remaining_q  <= '0;
            checksum_q   <= '0;
            instrValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            loadAddr_q   <= loadAddr_d;
            remaining_q  <= remaining_d;
            checksum_q   <= checksum_d;
            instrValid_q <= instrValid_d;
        end
    end

    // Next-state logic for the loader. A start with a zero count skips LOAD
    // and goes straight to DONE so the caller still sees a done pulse.
    // The address register is ADDR_W wide, so +1 wraps DEPTH-1 to 0.
    always_comb begin
        state_d     = state_q;
        loadAddr_d  = loadAddr_q;
        remaining_d = remaining_q;
        checksum_d  = checksum_q;
        memWrEn     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_load_start) begin
                    loadAddr_d  = i_load_base;
                    remaining_d = i_load_count;
                    checksum_d  = '0;
                    state_d     = (i_load_count == CNT_ZERO) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (i_load_valid) begin
                    memWrEn     = ~i_reset;
                    loadAddr_d  = loadAddr_q + ADDR_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    checksum_d  = checksum_q + i_load_data;
                    if (remaining_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fetches are only served from IDLE; any other cycle produces an
    // invalid, zeroed output on the following cycle.
    always_comb begin
        fetchEn      = (state_q == IDLE) && i_enable;
        instrValid_d = fetchEn;
    end

`ifdef PROG_MEM_PARITY_EN
    // Stored parity bit makes the total weight of each stored word even.
    assign memWrData    = {^i_load_data, i_load_data};
    assign o_parity_err = instrValid_q & (^memRdData);
`else
    assign memWrData    = i_load_data;
    assign o_parity_err = 1'b0;
`endif

    prog_mem_array #(
        .WIDTH  (MEM_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .wrEn_i   (memWrEn),
        .wrAddr_i (loadAddr_q),
        .wrData_i (memWrData),
        .rdEn_i   (fetchEn),
        .rdAddr_i (i_address),
        .rdData_o (memRdData)
    );

    // The read register keeps stale data between fetches, so the word is
    // masked to zero whenever the valid flag is low.
    assign o_instruction = instrValid_q ? memRdData[INSTR_W-1:0] : '0;
    assign o_instr_valid = instrValid_q;
    assign o_load_ready  = (state_q == LOAD);
    assign o_busy        = (state_q == LOAD);
    assign o_load_done   = (state_q == DONE);
    assign o_checksum    = checksum_q;

    // DEPTH is kept for readers of this file; it documents the count range.
    logic unusedDepth;
    assign unusedDepth = (DEPTH == 0);

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_ctrl
// Directed self-checking bench for prog_mem_ctrl. Each scenario task drives
// its stimulus and checks results against hand-computed values.
// Optional: PROG_MEM_PARITY_EN enables the parity-error scenario.
// ---------------------------------------------------------------------------
module tb_prog_mem_ctrl;

    logic        clk;
    logic        i_reset;
    logic        i_enable;
    logic [7:0]  i_address;
    logic [13:0] o_instruction;
    logic        o_instr_valid;
    logic        i_load_start;
    logic [7:0]  i_load_base;
    logic [8:0]  i_load_count;
    logic        i_load_valid;
    logic [13:0] i_load_data;
    logic        o_load_ready;
    logic        o_load_done;
    logic        o_busy;
    logic [13:0] o_checksum;
    logic        o_parity_err;

    int assertCount;
    int failCount;

    logic [13:0] loadWords [16];
    int          doneSeen;
    logic        loadTimeout;

    prog_mem_ctrl #(
        .INSTR_W (14),
        .ADDR_W  (8)
    ) u_dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_address     (i_address),
        .o_instruction (o_instruction),
        .o_instr_valid (o_instr_valid),
        .i_load_start  (i_load_start),
        .i_load_base   (i_load_base),
        .i_load_count  (i_load_count),
        .i_load_valid  (i_load_valid),
        .i_load_data   (i_load_data),
        .o_load_ready  (o_load_ready),
        .o_load_done   (o_load_done),
        .o_busy        (o_busy),
        .o_checksum    (o_checksum),
        .o_parity_err  (o_parity_err)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs are driven and outputs sampled 1 unit after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single fetch: request in one cycle, result visible after the next edge.
    task automatic applyStimulus(input logic [7:0] addr, output logic [13:0] ins,
                                 output logic vld, output logic perr);
        i_enable  = 1'b1;
        i_address = addr;
        tick();
        i_enable  = 1'b0;
        ins  = o_instruction;
        vld  = o_instr_valid;
        perr = o_parity_err;
    endtask

    // Full load session from loadWords[] with valid held high. Records the
    // number of done pulses seen and whether ready ever failed to appear.
    task automatic runLoad(input logic [7:0] base, input logic [8:0] count);
        int idx;
        int waitCycles;
        loadTimeout  = 1'b0;
        doneSeen     = 0;
        i_load_base  = base;
        i_load_count = count;
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        idx = 0;
        waitCycles = 0;
        while (idx < int'(count) && waitCycles < 200) begin
            if (o_load_ready) begin
                i_load_valid = 1'b1;
                i_load_data  = loadWords[idx];
                idx++;
            end else begin
                i_load_valid = 1'b0;
            end
            tick();
            waitCycles++;
        end
        i_load_valid = 1'b0;
        if (idx < int'(count)) loadTimeout = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (o_load_done) doneSeen++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [13:0] ins;
        logic vld;
        logic perr;
        i_reset = 1'b1;
        tick();
        tick();
        assertCount++; if (o_instruction !== 14'h0) begin failCount++; $display("[TB] FAIL reset_instruction: got %h expected 0000", o_instruction); end
        assertCount++; if (o_instr_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", o_instr_valid); end
        assertCount++; if (o_load_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_load_ready: got %b expected 0", o_load_ready); end
        assertCount++; if (o_load_done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_load_done: got %b expected 0", o_load_done); end
        assertCount++; if (o_busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
        assertCount++; if (o_checksum !== 14'h0) begin failCount++; $display("[TB] FAIL reset_checksum: got %h expected 0000", o_checksum); end
        assertCount++; if (o_parity_err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_parity_err: got %b expected 0", o_parity_err); end
        i_reset = 1'b0;
        tick();
        // Preload words 0x0100..0x0107 at 0x00..0x07, then fetch 0x05.
        for (int i = 0; i < 8; i++) loadWords[i] = 14'h0100 + 14'(i);
        runLoad(8'h00, 9'd8);
        applyStimulus(8'h05, ins, vld, perr);
        assertCount++; if (vld !== 1'b1) begin failCount++; $display("[TB] FAIL fetch05_valid: got %b expected 1", vld); end
        assertCount++; if (ins !== 14'h0105) begin failCount++; $display("[TB] FAIL fetch05_data: got %h expected 0105", ins); end
        assertCount++; if (perr !== 1'b0) begin failCount++; $display("[TB] FAIL fetch05_parity: got %b expected 0", perr); end
        tick();
        assertCount++; if (o_instr_valid !== 1'b0 || o_instruction !== 14'h0) begin failCount++; $display("[TB] FAIL idle_no_fetch: got valid %b data %h expected 0 0000", o_instr_valid, o_instruction); end
    endtask

    task automatic test_basic_load();
        logic [13:0] ins;
        logic vld;
        logic perr;
        loadWords[0] = 14'h0001;
        loadWords[1] = 14'h0002;
        loadWords[2] = 14'h3FFF;
        runLoad(8'h10, 9'd3);
        assertCount++; if (loadTimeout !== 1'b0) begin failCount++; $display("[TB] FAIL basic_timeout: got %b expected 0", loadTimeout); end
        assertCount++; if (doneSeen !== 1) begin failCount++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", doneSeen); end
        assertCount++; if (o_checksum !== 14'h0002) begin failCount++; $display("[TB] FAIL basic_checksum: got %h expected 0002", o_checksum); end
        assertCount++; if (o_busy !== 1'b0) begin failCount++; $display("[TB] FAIL basic_busy_after: got %b expected 0", o_busy); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h10 + 8'(i), ins, vld, perr);
            assertCount++; if (vld !== 1'b1 || ins !== loadWords[i]) begin failCount++; $display("[TB] FAIL basic_mem_%0d: got valid %b data %h expected 1 %h", i, vld, ins, loadWords[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [13:0] ins;
        logic vld;
        logic perr;
        logic [13:0] w [4];
        logic [7:0]  a [4];
        w[0] = 14'h1111; w[1] = 14'h2222; w[2] = 14'h0333; w[3] = 14'h0444;
        a[0] = 8'hFE;    a[1] = 8'hFF;    a[2] = 8'h00;    a[3] = 8'h01;
        i_load_base  = 8'hFE;
        i_load_count = 9'd4;
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        assertCount++; if (o_busy !== 1'b1 || o_load_ready !== 1'b1) begin failCount++; $display("[TB] FAIL wrap_busy_ready: got %b %b expected 1 1", o_busy, o_load_ready); end
        for (int i = 0; i < 4; i++) begin
            i_enable     = (i == 0);
            i_address    = 8'h10;
            i_load_valid = 1'b1;
            i_load_data  = w[i];
            tick();
            if (i == 0) begin
                assertCount++; if (o_instr_valid !== 1'b0 || o_instruction !== 14'h0) begin failCount++; $display("[TB] FAIL wrap_fetch_blocked: got valid %b data %h expected 0 0000", o_instr_valid, o_instruction); end
            end
        end
        i_enable     = 1'b0;
        i_load_valid = 1'b0;
        assertCount++; if (o_load_done !== 1'b1) begin failCount++; $display("[TB] FAIL wrap_done: got %b expected 1", o_load_done); end
        assertCount++; if (o_checksum !== 14'h3AAA) begin failCount++; $display("[TB] FAIL wrap_checksum: got %h expected 3aaa", o_checksum); end
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(a[i], ins, vld, perr);
            assertCount++; if (vld !== 1'b1 || ins !== w[i]) begin failCount++; $display("[TB] FAIL wrap_mem_%h: got valid %b data %h expected 1 %h", a[i], vld, ins, w[i]); end
        end
    endtask

    task automatic test_handshake();
        logic [13:0] ins;
        logic vld;
        logic perr;
        logic        vPat [4];
        logic [13:0] dPat [4];
        vPat[0] = 1'b1; vPat[1] = 1'b0; vPat[2] = 1'b1; vPat[3] = 1'b1;
        dPat[0] = 14'h0AA1; dPat[1] = 14'h3FF0; dPat[2] = 14'h0AA2; dPat[3] = 14'h0AA3;
        // Valid while idle must not write anything.
        i_load_valid = 1'b1;
        i_load_data  = 14'h1234;
        tick();
        i_load_base  = 8'h20;
        i_load_count = 9'd3;
        i_load_start = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            i_load_valid = vPat[k];
            i_load_data  = dPat[k];
            i_load_start = (k == 1);
            i_load_base  = (k == 1) ? 8'h40 : 8'h20;
            i_load_count = (k == 1) ? 9'd5 : 9'd3;
            tick();
        end
        i_load_valid = 1'b0;
        i_load_start = 1'b0;
        assertCount++; if (o_load_done !== 1'b1) begin failCount++; $display("[TB] FAIL hs_done: got %b expected 1", o_load_done); end
        assertCount++; if (o_checksum !== 14'h1FE6) begin failCount++; $display("[TB] FAIL hs_checksum: got %h expected 1fe6", o_checksum); end
        tick();
        assertCount++; if (o_load_done !== 1'b0 || o_busy !== 1'b0) begin failCount++; $display("[TB] FAIL hs_after_done: got done %b busy %b expected 0 0", o_load_done, o_busy); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h20 + 8'(i), ins, vld, perr);
            assertCount++; if (ins !== 14'h0AA1 + 14'(i)) begin failCount++; $display("[TB] FAIL hs_mem_%0d: got %h expected %h", i, ins, 14'h0AA1 + 14'(i)); end
        end
        // Zero-count session: done in the cycle right after the start.
        i_load_base  = 8'h30;
        i_load_count = 9'd0;
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        assertCount++; if (o_load_done !== 1'b1 || o_busy !== 1'b0) begin failCount++; $display("[TB] FAIL zero_done: got done %b busy %b expected 1 0", o_load_done, o_busy); end
        assertCount++; if (o_checksum !== 14'h0) begin failCount++; $display("[TB] FAIL zero_checksum: got %h expected 0000", o_checksum); end
        tick();
        assertCount++; if (o_load_done !== 1'b0) begin failCount++; $display("[TB] FAIL zero_done_drop: got %b expected 0", o_load_done); end
    endtask

    task automatic test_reset_abort();
        logic [13:0] ins;
        logic vld;
        logic perr;
        int doneCount;
        i_load_base  = 8'h50;
        i_load_count = 9'd5;
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        i_load_valid = 1'b1;
        i_load_data  = 14'h0150;
        tick();
        i_load_data  = 14'h0151;
        tick();
        i_load_valid = 1'b0;
        i_reset      = 1'b1;
        tick();
        i_reset      = 1'b0;
        assertCount++; if (o_busy !== 1'b0 || o_load_ready !== 1'b0) begin failCount++; $display("[TB] FAIL abort_idle: got busy %b ready %b expected 0 0", o_busy, o_load_ready); end
        assertCount++; if (o_checksum !== 14'h0) begin failCount++; $display("[TB] FAIL abort_checksum: got %h expected 0000", o_checksum); end
        doneCount = 0;
        for (int k = 0; k < 3; k++) begin
            if (o_load_done) doneCount++;
            tick();
        end
        assertCount++; if (doneCount !== 0) begin failCount++; $display("[TB] FAIL abort_no_done: got %0d expected 0", doneCount); end
        applyStimulus(8'h50, ins, vld, perr);
        assertCount++; if (ins !== 14'h0150) begin failCount++; $display("[TB] FAIL abort_mem50: got %h expected 0150", ins); end
        applyStimulus(8'h51, ins, vld, perr);
        assertCount++; if (ins !== 14'h0151) begin failCount++; $display("[TB] FAIL abort_mem51: got %h expected 0151", ins); end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp [3];
        exp[0] = 14'h0001; exp[1] = 14'h0002; exp[2] = 14'h3FFF;
        i_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_address = 8'h10 + 8'(i);
            tick();
            assertCount++; if (o_instr_valid !== 1'b1 || o_instruction !== exp[i]) begin failCount++; $display("[TB] FAIL b2b_%0d: got valid %b data %h expected 1 %h", i, o_instr_valid, o_instruction, exp[i]); end
        end
        i_enable = 1'b0;
        tick();
        assertCount++; if (o_instr_valid !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_stop: got %b expected 0", o_instr_valid); end
    endtask

`ifdef PROG_MEM_PARITY_EN
    task automatic test_parity();
        logic [13:0] ins;
        logic vld;
        logic perr;
        u_dut.u_array.mem[8'h05] = u_dut.u_array.mem[8'h05] ^ 15'h0001;
        applyStimulus(8'h05, ins, vld, perr);
        assertCount++; if (perr !== 1'b1) begin failCount++; $display("[TB] FAIL parity_err: got %b expected 1", perr); end
        assertCount++; if (ins !== 14'h0104) begin failCount++; $display("[TB] FAIL parity_data: got %h expected 0104", ins); end
        applyStimulus(8'h06, ins, vld, perr);
        assertCount++; if (perr !== 1'b0) begin failCount++; $display("[TB] FAIL parity_clean: got %b expected 0", perr); end
    endtask
`endif

    // Scenario sequence.
    initial begin
        assertCount  = 0;
        failCount    = 0;
        i_reset      = 1'b1;
        i_enable     = 1'b0;
        i_address    = 8'h00;
        i_load_start = 1'b0;
        i_load_base  = 8'h00;
        i_load_count = 9'd0;
        i_load_valid = 1'b0;
        i_load_data  = 14'h0;
        test_reset();
        test_basic_load();
        test_wrap();
        test_handshake();
        test_reset_abort();
        test_back_to_back();
`ifdef PROG_MEM_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
